four_dround_dpct_clk_3s: RTL and testbench



---
 rtl/four_dround_dpct_clk_3s.sv | 159 +++++++++++++++
 tb/tb_four_dround_dpct_clk_3s.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/four_dround_dpct_clk_3s.sv
// Iterative Salsa20/8 core: one Salsa20 round per clock, then a word-wise feed-forward add.
// A start/done handshake frames each computation; the result stays registered until the next one.
module four_dround_dpct_clk_3s (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] xx0,
   input  logic [31:0] xx1,
   input  logic [31:0] xx2,
   input  logic [31:0] xx3,
   input  logic [31:0] xx4,
   input  logic [31:0] xx5,
   input  logic [31:0] xx6,
   input  logic [31:0] xx7,
   input  logic [31:0] xx8,
   input  logic [31:0] xx9,
   input  logic [31:0] xx10,
   input  logic [31:0] xx11,
   input  logic [31:0] xx12,
   input  logic [31:0] xx13,
   input  logic [31:0] xx14,
   input  logic [31:0] xx15,
   output logic [31:0] out0,
   output logic [31:0] out1,
   output logic [31:0] out2,
   output logic [31:0] out3,
   output logic [31:0] out4,
   output logic [31:0] out5,
   output logic [31:0] out6,
   output logic [31:0] out7,
   output logic [31:0] out8,
   output logic [31:0] out9,
   output logic [31:0] out10,
   output logic [31:0] out11,
   output logic [31:0] out12,
   output logic [31:0] out13,
   output logic [31:0] out14,
   output logic [31:0] out15,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, CALC, FINAL, DONE} state_t;

   state_t      state_reg, state_next;
   logic [2:0]  rc_reg;
   logic        done_reg;
   logic [31:0] xx      [16];
   logic [31:0] s_reg   [16];
   logic [31:0] o_reg   [16];
   logic [31:0] out_reg [16];
   logic [31:0] col_s   [16];
   logic [31:0] row_s   [16];

   // Quarter-round operand order (a,b,c,d) for each of the four parallel QRs.
   localparam int COL_IDX [16] = '{0, 4, 8, 12, 5, 9, 13, 1, 10, 14, 2, 6, 15, 3, 7, 11};
   localparam int ROW_IDX [16] = '{0, 1, 2, 3, 5, 6, 7, 4, 10, 11, 8, 9, 15, 12, 13, 14};

   function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction

   function automatic logic [127:0] quarter(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c, input logic [31:0] d);
      logic [31:0] a2, b2, c2, d2;
      b2 = b ^ rotl(a + d, 7);
      c2 = c ^ rotl(b2 + a, 9);
      d2 = d ^ rotl(c2 + b2, 13);
      a2 = a ^ rotl(d2 + c2, 18);
      return {a2, b2, c2, d2};
   endfunction

   assign xx[0]  = xx0;   assign xx[1]  = xx1;   assign xx[2]  = xx2;   assign xx[3]  = xx3;
   assign xx[4]  = xx4;   assign xx[5]  = xx5;   assign xx[6]  = xx6;   assign xx[7]  = xx7;
   assign xx[8]  = xx8;   assign xx[9]  = xx9;   assign xx[10] = xx10;  assign xx[11] = xx11;
   assign xx[12] = xx12;  assign xx[13] = xx13;  assign xx[14] = xx14;  assign xx[15] = xx15;

   // Both round flavours are built every cycle; the round counter's LSB picks one.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_qr
         logic [127:0] col_q, row_q;
         assign col_q = quarter(s_reg[COL_IDX[4*gi]],   s_reg[COL_IDX[4*gi+1]],
                                s_reg[COL_IDX[4*gi+2]], s_reg[COL_IDX[4*gi+3]]);
         assign row_q = quarter(s_reg[ROW_IDX[4*gi]],   s_reg[ROW_IDX[4*gi+1]],
                                s_reg[ROW_IDX[4*gi+2]], s_reg[ROW_IDX[4*gi+3]]);
         assign col_s[COL_IDX[4*gi]]   = col_q[127:96];
         assign col_s[COL_IDX[4*gi+1]] = col_q[95:64];
         assign col_s[COL_IDX[4*gi+2]] = col_q[63:32];
         assign col_s[COL_IDX[4*gi+3]] = col_q[31:0];
         assign row_s[ROW_IDX[4*gi]]   = row_q[127:96];
         assign row_s[ROW_IDX[4*gi+1]] = row_q[95:64];
         assign row_s[ROW_IDX[4*gi+2]] = row_q[63:32];
         assign row_s[ROW_IDX[4*gi+3]] = row_q[31:0];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = CALC;
         CALC:    if (rc_reg == 3'd7) state_next = FINAL;
         FINAL:   state_next = DONE;
         DONE:    if (!start) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rc_reg   <= 3'd0;
         done_reg <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            s_reg[i]   <= 32'd0;
            o_reg[i]   <= 32'd0;
            out_reg[i] <= 32'd0;
         end
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  rc_reg <= 3'd0;
                  for (int i = 0; i < 16; i++) begin
                     s_reg[i] <= xx[i];
                     o_reg[i] <= xx[i];
                  end
               end
            end
            CALC: begin
               rc_reg <= rc_reg + 3'd1;
               for (int i = 0; i < 16; i++)
                  s_reg[i] <= rc_reg[0] ? row_s[i] : col_s[i];
            end
            FINAL: begin
               done_reg <= 1'b1;
               for (int i = 0; i < 16; i++)
                  out_reg[i] <= o_reg[i] + s_reg[i];
            end
            DONE: begin
               if (!start) done_reg <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign done  = done_reg;
   assign out0  = out_reg[0];   assign out1  = out_reg[1];   assign out2  = out_reg[2];
   assign out3  = out_reg[3];   assign out4  = out_reg[4];   assign out5  = out_reg[5];
   assign out6  = out_reg[6];   assign out7  = out_reg[7];   assign out8  = out_reg[8];
   assign out9  = out_reg[9];   assign out10 = out_reg[10];  assign out11 = out_reg[11];
   assign out12 = out_reg[12];  assign out13 = out_reg[13];  assign out14 = out_reg[14];
   assign out15 = out_reg[15];

endmodule

// File: tb/tb_four_dround_dpct_clk_3s.sv
// Bench for the iterative Salsa20/8 core: directed and random transactions against a
// software Salsa20/8 model, plus handshake, latency and mid-run reset behaviour.
module tb_four_dround_dpct_clk_3s;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] xin  [16];
   logic [31:0] outs [16];
   logic        done;

   int errors = 0;
   int checks = 0;

   logic [31:0] m_in  [16];
   logic [31:0] m_x   [16];
   logic [31:0] m_out [16];

   logic [31:0] rfc_in [16] = '{32'h219a877e, 32'h86c93e4f, 32'he640a97c, 32'h268f7141,
                                32'h5b55eeba, 32'hb5c1618c, 32'h1146f80d, 32'h1d3bcd6d,
                                32'h19f324ee, 32'h853d9bdf, 32'h4b1e1214, 32'h32aac55a,
                                32'h291d0276, 32'h2948c709, 32'h8dc6ebed, 32'h5ec2b8b8};
   logic [31:0] rfc_out [16] = '{32'h9c851fa4, 32'h99cc0866, 32'hcbca813b, 32'h05ef0c02,
                                 32'h81214b04, 32'h7d33fda2, 32'h631c7bfd, 32'h292f6896,
                                 32'h683139b4, 32'hbce6c9e3, 32'hb7c56bfe, 32'hba966da0,
                                 32'h10cc24e4, 32'h5c74912c, 32'h3d67ad24, 32'h818f61c7};
   logic [31:0] pat [4] = '{32'hae042d63, 32'hc3823f85, 32'h2d0a38cd, 32'h7af25f75};

   always #5 clk = ~clk;

   four_dround_dpct_clk_3s dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .xx0(xin[0]),   .xx1(xin[1]),   .xx2(xin[2]),   .xx3(xin[3]),
      .xx4(xin[4]),   .xx5(xin[5]),   .xx6(xin[6]),   .xx7(xin[7]),
      .xx8(xin[8]),   .xx9(xin[9]),   .xx10(xin[10]), .xx11(xin[11]),
      .xx12(xin[12]), .xx13(xin[13]), .xx14(xin[14]), .xx15(xin[15]),
      .out0(outs[0]),   .out1(outs[1]),   .out2(outs[2]),   .out3(outs[3]),
      .out4(outs[4]),   .out5(outs[5]),   .out6(outs[6]),   .out7(outs[7]),
      .out8(outs[8]),   .out9(outs[9]),   .out10(outs[10]), .out11(outs[11]),
      .out12(outs[12]), .out13(outs[13]), .out14(outs[14]), .out15(outs[15]),
      .done(done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction

   task automatic mqr(input int a, input int b, input int c, input int d);
      m_x[b] = m_x[b] ^ rotl(m_x[a] + m_x[d], 7);
      m_x[c] = m_x[c] ^ rotl(m_x[b] + m_x[a], 9);
      m_x[d] = m_x[d] ^ rotl(m_x[c] + m_x[b], 13);
      m_x[a] = m_x[a] ^ rotl(m_x[d] + m_x[c], 18);
   endtask

   // Textbook Salsa20/8: four double rounds then feed-forward.
   task automatic model();
      for (int i = 0; i < 16; i++) m_x[i] = m_in[i];
      for (int r = 0; r < 4; r++) begin
         mqr(0, 4, 8, 12);  mqr(5, 9, 13, 1);  mqr(10, 14, 2, 6);  mqr(15, 3, 7, 11);
         mqr(0, 1, 2, 3);   mqr(5, 6, 7, 4);   mqr(10, 11, 8, 9);  mqr(15, 12, 13, 14);
      end
      for (int i = 0; i < 16; i++) m_out[i] = m_x[i] + m_in[i];
   endtask

   task automatic randomize_inputs();
      for (int i = 0; i < 16; i++) xin[i] = $urandom;
   endtask

   // Raise start with xin presented; E0 is the next edge. Optionally scramble xin after E0.
   task automatic do_txn(input string name, input bit scramble);
      int lat;
      for (int i = 0; i < 16; i++) m_in[i] = xin[i];
      model();
      start = 1'b1;
      @(posedge clk); #1;
      lat = 0;
      while (done !== 1'b1 && lat < 40) begin
         if (scramble) randomize_inputs();
         @(posedge clk); #1;
         lat++;
      end
      chk({name, "_latency"}, lat, 32'd9);
      for (int i = 0; i < 16; i++)
         chk($sformatf("%s_out%0d", name, i), outs[i], m_out[i]);
      $display("txn %s latency=%0d out0=%h expect0=%h out15=%h expect15=%h",
               name, lat, outs[0], m_out[0], outs[15], m_out[15]);
   endtask

   task automatic drop(input string name);
      start = 1'b0;
      @(posedge clk); #1;
      chk({name, "_done_fall"}, {31'd0, done}, 32'd0);
      chk({name, "_out_hold"}, outs[3], m_out[3]);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      for (int i = 0; i < 16; i++) xin[i] = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_done", {31'd0, done}, 32'd0);
      for (int i = 0; i < 16; i++) chk($sformatf("reset_out%0d", i), outs[i], 32'd0);

      rst_n = 1'b1;
      do_txn("zero", 1'b0);
      for (int i = 0; i < 16; i++) chk($sformatf("zero_const%0d", i), outs[i], 32'd0);
      drop("zero");

      for (int i = 0; i < 16; i++) xin[i] = rfc_in[i];
      do_txn("rfc7914", 1'b0);
      for (int i = 0; i < 16; i++) chk($sformatf("rfc7914_const%0d", i), outs[i], rfc_out[i]);
      drop("rfc7914");

      for (int i = 0; i < 16; i++) xin[i] = pat[i % 4];
      do_txn("pattern", 1'b0);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         chk("hold_done", {31'd0, done}, 32'd1);
         chk("hold_out5", outs[5], m_out[5]);
      end
      drop("pattern");

      randomize_inputs();
      do_txn("restart", 1'b0);
      drop("restart");

      randomize_inputs();
      do_txn("scramble", 1'b1);
      drop("scramble");

      // Reset lands on E4, mid-computation.
      randomize_inputs();
      start = 1'b1;
      @(posedge clk); #1;
      repeat (3) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("midreset_done", {31'd0, done}, 32'd0);
      for (int i = 0; i < 16; i++) chk($sformatf("midreset_out%0d", i), outs[i], 32'd0);
      rst_n = 1'b1;
      randomize_inputs();
      do_txn("after_reset", 1'b0);
      drop("after_reset");

      for (int t = 0; t < 3; t++) begin
         randomize_inputs();
         do_txn($sformatf("random%0d", t), 1'b0);
         drop($sformatf("random%0d", t));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
